// File: rtl/mdu_iter.sv
// Iterative RV M-extension multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider sharing one accumulator, with valid/ready on both sides.
module mdu_iter #(
    parameter int WIDTH     = 32,
    parameter bit FAST_DIV0 = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic             r_neg_p;   // product / quotient sign
    logic             r_neg_r;   // remainder sign
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;      // product high half / partial remainder
    logic [WIDTH-1:0] r_lo;      // multiplier, then product low half / dividend, then quotient
    logic [WIDTH-1:0] r_opb;     // multiplicand / divisor
    logic [WIDTH-1:0] r_res;

    // Request decode: which operands are signed, magnitudes and special cases.
    logic             w_sgn1, w_sgn2, w_neg1, w_neg2, w_div0, w_ovf, w_fast;
    logic [WIDTH-1:0] w_mag1, w_mag2, w_fast_res;

    assign w_sgn1 = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    assign w_sgn2 = op[2] ? ~op[0] : ~op[1];
    assign w_neg1 = w_sgn1 & src1[WIDTH-1];
    assign w_neg2 = w_sgn2 & src2[WIDTH-1];
    assign w_mag1 = w_neg1 ? -src1 : src1;
    assign w_mag2 = w_neg2 ? -src2 : src2;
    assign w_div0 = (src2 == '0);
    assign w_ovf  = op[2] & ~op[0] & (src1 == {1'b1, {(WIDTH-1){1'b0}}}) & (src2 == '1);
    assign w_fast = FAST_DIV0 & op[2] & (w_div0 | w_ovf);

    always_comb begin
        if (w_div0)
            w_fast_res = op[1] ? src1 : '1;
        else
            w_fast_res = op[1] ? '0 : src1;
    end

    // One iteration of each algorithm; the multiply sum carries into bit WIDTH.
    logic [WIDTH:0]   w_mul_sum, w_div_shift, w_div_diff;
    logic             w_div_keep;
    logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt;

    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
        w_div_shift = {r_hi, r_lo[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        w_div_keep  = ~w_div_diff[WIDTH];
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        if (r_op[2]) begin
            w_hi_nxt = w_div_keep ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_div_keep};
        end else begin
            w_hi_nxt = w_mul_sum[WIDTH:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // Sign correction and result select.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem, w_fix_res;

    always_comb begin
        w_prod = r_neg_p ? -{r_hi, r_lo} : {r_hi, r_lo};
        w_quo  = r_neg_p ? -r_lo : r_lo;
        w_rem  = r_neg_r ? -r_hi : r_hi;
        if (r_div0)
            w_quo = '1;
        case (r_op)
            3'b000:                 w_fix_res = w_prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_fix_res = w_quo;
            default:                w_fix_res = w_rem;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = w_fast ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush)
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_neg_p <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opb   <= '0;
            r_res   <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_cnt   <= '0;
                    r_op    <= op;
                    r_neg_p <= w_neg1 ^ w_neg2;
                    r_neg_r <= w_neg1;
                    r_div0  <= op[2] & w_div0;
                    r_hi    <= '0;
                    r_lo    <= op[2] ? w_mag1 : w_mag2;
                    r_opb   <= op[2] ? w_mag2 : w_mag1;
                    if (w_fast)
                        r_res <= w_fast_res;
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                end
                S_FIX:   r_res <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign res       = r_res;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: a fast-special-case and an iterating instance share stimulus;
// results are compared against a plain-arithmetic M-extension model.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, out_ready;
    logic [2:0]   op;
    logic [W-1:0] src1, src2;
    logic         in_ready_f, out_valid_f, busy_f;
    logic         in_ready_s, out_valid_s, busy_s;
    logic [W-1:0] res_f, res_s;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_exp;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W), .FAST_DIV0(1'b1)) u_fast (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_f),
        .op(op), .src1(src1), .src2(src2), .out_valid(out_valid_f), .out_ready(out_ready),
        .res(res_f), .busy(busy_f)
    );

    mdu_iter #(.WIDTH(W), .FAST_DIV0(1'b0)) u_slow (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
        .op(op), .src1(src1), .src2(src2), .out_valid(out_valid_s), .out_ready(out_ready),
        .res(res_s), .busy(busy_s)
    );

    function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        longint         sa, sb, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'(b);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[W-1:0]; end
            3'd1: begin p = sa * sb;                 return p[2*W-1:W]; end
            3'd2: begin p = sa * ub;                 return p[2*W-1:W]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[2*W-1:W]; end
            3'd4: return (b == 0) ? '1 : 32'(sa / sb);
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: return (b == 0) ? a : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int fast_latency(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; samples until both instances show out_valid.
    task automatic collect(input string name, input logic [W-1:0] exp, input int lat_f);
        int           got_f_lat = 0;
        int           got_s_lat = 0;
        logic [W-1:0] got_f = '0;
        logic [W-1:0] got_s = '0;
        bit           hs_bad = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (got_f_lat == 0) begin
                if (out_valid_f === 1'b1) begin got_f_lat = n; got_f = res_f; end
                else if (in_ready_f !== 1'b0 || busy_f !== 1'b1) hs_bad = 1'b1;
            end
            if (got_s_lat == 0) begin
                if (out_valid_s === 1'b1) begin got_s_lat = n; got_s = res_s; end
                else if (in_ready_s !== 1'b0 || busy_s !== 1'b1) hs_bad = 1'b1;
            end
            if (got_f_lat != 0 && got_s_lat != 0) break;
            tick();
        end
        checks += 5;
        if (got_f_lat !== lat_f) begin errors++; $display("FAIL %s fast latency: got %0d expected %0d", name, got_f_lat, lat_f); end
        if (got_s_lat !== 34)    begin errors++; $display("FAIL %s iter latency: got %0d expected 34", name, got_s_lat); end
        if (got_f !== exp)       begin errors++; $display("FAIL %s fast res: got %h expected %h", name, got_f, exp); end
        if (got_s !== exp)       begin errors++; $display("FAIL %s iter res: got %h expected %h", name, got_s, exp); end
        if (hs_bad)              begin errors++; $display("FAIL %s busy handshake: got in_ready=1/busy=0 expected in_ready=0/busy=1", name); end
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] exp;
        exp = model(f, a, b);
        op = f; src1 = a; src2 = b;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        op = 3'($urandom); src1 = $urandom; src2 = $urandom;
        collect(name, exp, fast_latency(f, a, b));
        tick();
        last_exp = exp;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; src1 = '0; src2 = '0;
        tick(); tick();
        rst = 1'b0;
        checks += 2;
        if ({in_ready_f, out_valid_f, busy_f, res_f} !== {3'b100, 32'h0}) begin
            errors++; $display("FAIL reset fast: got rdy/vld/busy/res %b%b%b/%h expected 100/0", in_ready_f, out_valid_f, busy_f, res_f);
        end
        if ({in_ready_s, out_valid_s, busy_s, res_s} !== {3'b100, 32'h0}) begin
            errors++; $display("FAIL reset iter: got rdy/vld/busy/res %b%b%b/%h expected 100/0", in_ready_s, out_valid_s, busy_s, res_s);
        end
    endtask

    task automatic test_directed;
        run_op("mul",        3'd0, 32'h7FFF_FFFF, 32'h0000_0002);
        run_op("mulh",       3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        run_op("mulhu",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu",     3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op("div",        3'd4, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op("rem",        3'd6, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op("divu",       3'd5, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op("divu_by0",   3'd5, 32'h0000_0005, 32'h0);
        run_op("remu_by0",   3'd7, 32'h0000_0005, 32'h0);
        run_op("div_by0",    3'd4, 32'hFFFF_FFFB, 32'h0);
        run_op("rem_by0",    3'd6, 32'hFFFF_FFFB, 32'h0);
        run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic [2:0]   f;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       begin a = 32'h8000_0000; b = '1; end
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op("random", f, a, b);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp1, exp2;
        bit           hold_bad = 1'b0;
        exp1 = model(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        exp2 = model(3'd5, 32'hDEAD_BEEF, 32'h0000_0100);
        op = 3'd0; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        collect("bp_first", exp1, 34);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid_f !== 1'b1 || out_valid_s !== 1'b1 || in_ready_f !== 1'b0 ||
                in_ready_s !== 1'b0 || res_f !== exp1 || res_s !== exp1)
                hold_bad = 1'b1;
        end
        checks++;
        if (hold_bad) begin errors++; $display("FAIL bp_hold: got unstable DONE expected res=%h held with out_valid=1 in_ready=0", exp1); end
        op = 3'd5; src1 = 32'hDEAD_BEEF; src2 = 32'h0000_0100;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid_f, out_valid_s, in_ready_f, in_ready_s} !== 4'b0011) begin
            errors++; $display("FAIL bp_release: got vld/rdy %b%b%b%b expected 0011", out_valid_f, out_valid_s, in_ready_f, in_ready_s);
        end
        tick();
        in_valid = 1'b0;
        collect("bp_second", exp2, 34);
        tick();
        last_exp = exp2;
    endtask

    task automatic test_flush;
        bit seen = 1'b0;
        op = 3'd0; src1 = $urandom; src2 = $urandom;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks += 2;
        if ({in_ready_f, busy_f, out_valid_f} !== 3'b100 || res_f !== last_exp) begin
            errors++; $display("FAIL flush fast: got rdy/busy/vld %b%b%b res %h expected 100 res %h", in_ready_f, busy_f, out_valid_f, res_f, last_exp);
        end
        if ({in_ready_s, busy_s, out_valid_s} !== 3'b100 || res_s !== last_exp) begin
            errors++; $display("FAIL flush iter: got rdy/busy/vld %b%b%b res %h expected 100 res %h", in_ready_s, busy_s, out_valid_s, res_s, last_exp);
        end
        repeat (40) begin
            tick();
            if (out_valid_f === 1'b1 || out_valid_s === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL flush_no_result: got out_valid=1 expected 0"); end
        run_op("mul_after_flush", 3'd0, 32'd3, 32'd4);

        flush = 1'b1; in_valid = 1'b1; op = 3'd4; src1 = 32'd100; src2 = 32'd7;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({busy_f, busy_s, in_ready_f, in_ready_s} !== 4'b0011) begin
            errors++; $display("FAIL flush_with_valid: got busy/rdy %b%b%b%b expected 0011", busy_f, busy_s, in_ready_f, in_ready_s);
        end
    endtask

    task automatic test_reset_mid_calc;
        bit seen = 1'b0;
        op = 3'd4; src1 = $urandom; src2 = 32'($urandom_range(1, 1000));
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 2;
        if ({in_ready_f, out_valid_f, busy_f, res_f} !== {3'b100, 32'h0}) begin
            errors++; $display("FAIL rst_mid fast: got rdy/vld/busy/res %b%b%b/%h expected 100/0", in_ready_f, out_valid_f, busy_f, res_f);
        end
        if ({in_ready_s, out_valid_s, busy_s, res_s} !== {3'b100, 32'h0}) begin
            errors++; $display("FAIL rst_mid iter: got rdy/vld/busy/res %b%b%b/%h expected 100/0", in_ready_s, out_valid_s, busy_s, res_s);
        end
        repeat (40) begin
            tick();
            if (out_valid_f === 1'b1 || out_valid_s === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rst_no_result: got out_valid=1 expected 0"); end
        run_op("div_after_rst", 3'd4, 32'hFFFF_FF9C, 32'd7);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
